// File: rtl/imc_pkg.sv
// Shared types and pair-index helpers for the interlock matrix controller.
// Pair (i,j) with i<j lives at index j*(j-1)/2+i.
package imc_pkg;

  localparam int CONFLICT_CNT_W = 16;

  typedef enum logic [1:0] {
    IMC_IDLE   = 2'd0,
    IMC_BREAK  = 2'd1,
    IMC_SETTLE = 2'd2,
    IMC_MAKE   = 2'd3
  } imc_state_e;

  localparam logic [1:0] ST_IDLE   = IMC_IDLE;
  localparam logic [1:0] ST_BREAK  = IMC_BREAK;
  localparam logic [1:0] ST_SETTLE = IMC_SETTLE;
  localparam logic [1:0] ST_MAKE   = IMC_MAKE;

  function automatic int sw_idx(input int i, input int j);
    return j * (j - 1) / 2 + i;
  endfunction

  // Higher pole of switch k: largest j with j*(j-1)/2 <= k.
  function automatic int sw_hi(input int k);
    int hi;
    hi = 1;
    for (int j = 1; j < 256; j++) begin
      if (j * (j - 1) / 2 <= k) hi = j;
    end
    return hi;
  endfunction

  function automatic int sw_lo(input int k);
    int hi;
    hi = sw_hi(k);
    return k - hi * (hi - 1) / 2;
  endfunction

endpackage

// File: rtl/imc_pair_arbiter.sv
// Serial pair arbiter: visits one switch per cycle after start, granting the
// lowest-index requested switch whose two poles are requested and still free.
module imc_pair_arbiter
  import imc_pkg::*;
#(
  parameter int N_CH = 8,
  parameter int N_SW = N_CH * (N_CH - 1) / 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [N_CH-1:0] pole,
  input  logic [N_SW-1:0] sw,
  output logic [N_SW-1:0] grant,
  output logic            refused,
  output logic            done
);

  localparam int KW = (N_SW > 1) ? $clog2(N_SW) : 1;

  logic [N_CH-1:0] mask_v [N_SW];

  for (genvar g = 0; g < N_SW; g++) begin : g_mask
    localparam int LO = sw_lo(g);
    localparam int HI = sw_hi(g);
    assign mask_v[g] = (N_CH'(1) << LO) | (N_CH'(1) << HI);
  end

  logic [KW-1:0]   k_q, k_d;
  logic            run_q, run_d;
  logic            done_q, done_d;
  logic            refused_q, refused_d;
  logic [N_SW-1:0] grant_q, grant_d;
  logic [N_CH-1:0] held_q, held_d;
  logic [N_CH-1:0] cur_mask;
  logic            cur_elig;
  logic            cur_free;

  assign cur_mask = mask_v[k_q];
  assign cur_elig = sw[k_q] && ((pole & cur_mask) == cur_mask);
  assign cur_free = ((held_q & cur_mask) == '0);

  always_comb begin
    k_d       = k_q;
    run_d     = run_q;
    done_d    = done_q;
    refused_d = refused_q;
    grant_d   = grant_q;
    held_d    = held_q;
    if (start) begin
      k_d       = '0;
      run_d     = 1'b1;
      done_d    = 1'b0;
      refused_d = 1'b0;
      grant_d   = '0;
      held_d    = '0;
    end else if (run_q) begin
      // Switches with an unrequested endpoint are skipped silently.
      if (cur_elig) begin
        if (cur_free) begin
          grant_d[k_q] = 1'b1;
          held_d       = held_q | cur_mask;
        end else begin
          refused_d = 1'b1;
        end
      end
      if (k_q == KW'(N_SW - 1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end else begin
        k_d = k_q + KW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_q       <= '0;
      run_q     <= 1'b0;
      done_q    <= 1'b0;
      refused_q <= 1'b0;
      grant_q   <= '0;
      held_q    <= '0;
    end else begin
      k_q       <= k_d;
      run_q     <= run_d;
      done_q    <= done_d;
      refused_q <= refused_d;
      grant_q   <= grant_d;
      held_q    <= held_d;
    end
  end

  assign grant   = grant_q;
  assign refused = refused_q;
  assign done    = done_q;

endmodule

// File: rtl/interlock_matrix_ctrl.sv
// Break-before-make pole/switch interlock with a settle dwell and serial pair
// arbitration. Define IMC_CONFLICT_LOG_EN to enable the saturating refusal counter.
module interlock_matrix_ctrl
  import imc_pkg::*;
#(
  parameter  int N_CH       = 8,
  parameter  int SETTLE_CYC = 500000,
  localparam int N_SW       = N_CH * (N_CH - 1) / 2
) (
  input  logic                      pclk_50M,
  input  logic                      prst_n,
  input  logic [N_CH-1:0]           req_pole,
  input  logic [N_SW-1:0]           req_sw,
  output logic [N_CH-1:0]           en_pole,
  output logic [N_SW-1:0]           en_sw,
  output logic                      busy,
  output logic                      conflict,
  output logic [CONFLICT_CNT_W-1:0] conflict_cnt,
  output logic [1:0]                dbg_state
);

  localparam int CW = $clog2(SETTLE_CYC + 1);

  // Handshake: none; req_* are level requests, sampled every cycle through a
  // two-flop stage, and only a request stable across the whole dwell is applied.
  logic [N_CH-1:0] req_pole_q, req_pole_qq;
  logic [N_SW-1:0] req_sw_q, req_sw_qq;
  logic [N_CH-1:0] snap_pole_q, snap_pole_d;
  logic [N_SW-1:0] snap_sw_q, snap_sw_d;
  logic [N_CH-1:0] en_pole_q, en_pole_d;
  logic [N_SW-1:0] en_sw_q, en_sw_d;
  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            conflict_q, conflict_d;
  logic            stable;
  logic            changed;
  logic            arb_start;
  logic [N_SW-1:0] arb_grant;
  logic            arb_refused;
  logic            arb_done;

  assign stable  = (req_pole_q == req_pole_qq) && (req_sw_q == req_sw_qq);
  assign changed = (req_pole_q != snap_pole_q) || (req_sw_q != snap_sw_q);

  imc_pair_arbiter #(
    .N_CH (N_CH),
    .N_SW (N_SW)
  ) u_arb (
    .clk     (pclk_50M),
    .rst_n   (prst_n),
    .start   (arb_start),
    .pole    (req_pole_qq),
    .sw      (req_sw_qq),
    .grant   (arb_grant),
    .refused (arb_refused),
    .done    (arb_done)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    en_pole_d   = en_pole_q;
    en_sw_d     = en_sw_q;
    snap_pole_d = snap_pole_q;
    snap_sw_d   = snap_sw_q;
    conflict_d  = 1'b0;
    arb_start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Drives drop on entry so they read zero for the whole BREAK cycle.
        if (changed) begin
          state_d   = ST_BREAK;
          en_pole_d = '0;
          en_sw_d   = '0;
        end
      end
      ST_BREAK: begin
        en_pole_d = '0;
        en_sw_d   = '0;
        cnt_d     = '0;
        arb_start = 1'b1;
        state_d   = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!stable) begin
          state_d = ST_BREAK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(SETTLE_CYC - 1)) state_d = ST_MAKE;
        end
      end
      ST_MAKE: begin
        en_pole_d   = req_pole_qq;
        en_sw_d     = arb_done ? arb_grant : '0;
        snap_pole_d = req_pole_qq;
        snap_sw_d   = req_sw_qq;
        conflict_d  = arb_done & arb_refused;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk_50M) begin
    if (!prst_n) begin
      req_pole_q  <= '0;
      req_pole_qq <= '0;
      req_sw_q    <= '0;
      req_sw_qq   <= '0;
      snap_pole_q <= '0;
      snap_sw_q   <= '0;
      en_pole_q   <= '0;
      en_sw_q     <= '0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      conflict_q  <= 1'b0;
    end else begin
      req_pole_q  <= req_pole;
      req_pole_qq <= req_pole_q;
      req_sw_q    <= req_sw;
      req_sw_qq   <= req_sw_q;
      snap_pole_q <= snap_pole_d;
      snap_sw_q   <= snap_sw_d;
      en_pole_q   <= en_pole_d;
      en_sw_q     <= en_sw_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      conflict_q  <= conflict_d;
    end
  end

`ifdef IMC_CONFLICT_LOG_EN
  logic [CONFLICT_CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (conflict_d && (conflict_cnt_q != {CONFLICT_CNT_W{1'b1}}))
      conflict_cnt_d = conflict_cnt_q + CONFLICT_CNT_W'(1);
  end

  always_ff @(posedge pclk_50M) begin
    if (!prst_n) conflict_cnt_q <= '0;
    else         conflict_cnt_q <= conflict_cnt_d;
  end

  assign conflict_cnt = conflict_cnt_q;
`else
  assign conflict_cnt = '0;
`endif

  assign en_pole   = en_pole_q;
  assign en_sw     = en_sw_q;
  assign conflict  = conflict_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_interlock_matrix_ctrl.sv
// Directed bench for interlock_matrix_ctrl at N_CH=8, SETTLE_CYC=40.
module tb_interlock_matrix_ctrl;
  import imc_pkg::*;

  localparam int N_CH = 8;
  localparam int SC   = 40;
  localparam int N_SW = N_CH * (N_CH - 1) / 2;
  localparam int W    = N_CH + N_SW;
`ifdef IMC_CONFLICT_LOG_EN
  localparam int CC_ONE = 1;
`else
  localparam int CC_ONE = 0;
`endif

  logic            clk;
  logic            prst_n;
  logic [N_CH-1:0] req_pole;
  logic [N_SW-1:0] req_sw;
  logic [N_CH-1:0] en_pole;
  logic [N_SW-1:0] en_sw;
  logic            busy;
  logic            conflict;
  logic [15:0]     conflict_cnt;
  logic [1:0]      dbg_state;

  int n_tests;
  int n_fail;
  logic [W-1:0] exp_q[$];

  interlock_matrix_ctrl #(.N_CH(N_CH), .SETTLE_CYC(SC)) dut (
    .pclk_50M     (clk),
    .prst_n       (prst_n),
    .req_pole     (req_pole),
    .req_sw       (req_sw),
    .en_pole      (en_pole),
    .en_sw        (en_sw),
    .busy         (busy),
    .conflict     (conflict),
    .conflict_cnt (conflict_cnt),
    .dbg_state    (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver
  task automatic drive(input logic [N_CH-1:0] p, input logic [N_SW-1:0] s);
    req_pole = p;
    req_sw   = s;
  endtask

  // Runs n cycles; make_t is the cycle where busy falls (MAKE completes).
  task automatic window(input int n, output int make_t, output int busy_n,
                        output int zero_n, output int conf_n, output int brk_n);
    logic prev_busy;
    make_t = -1; busy_n = 0; zero_n = 0; conf_n = 0; brk_n = 0;
    prev_busy = busy;
    for (int t = 1; t <= n; t++) begin
      tick();
      if (busy) busy_n++;
      if (en_pole == '0 && en_sw == '0) zero_n++;
      if (conflict) conf_n++;
      if (dbg_state == ST_BREAK) brk_n++;
      if (prev_busy && !busy && make_t < 0) make_t = t;
      prev_busy = busy;
    end
  endtask

  task automatic wait_state(input logic [1:0] st, input int budget, input string tag);
    int i;
    i = 0;
    while (dbg_state != st && i < budget) begin
      tick();
      i++;
    end
    chk(tag, 64'(dbg_state), 64'(st));
  endtask

  // Scoreboard: compare applied drive with the oldest expected entry.
  task automatic check_applied(input string tag);
    logic [W-1:0] exp;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'(1), 64'(0));
    end else begin
      exp = exp_q.pop_front();
      chk(tag, 64'({en_pole, en_sw}), 64'(exp));
    end
  endtask

  initial begin
    int mk, bz, zr, cf, bk;
    n_tests = 0;
    n_fail  = 0;
    prst_n  = 1'b0;
    drive('0, '0);
    repeat (3) tick();
    chk("rst_en_pole", 64'(en_pole), 64'(0));
    chk("rst_en_sw", 64'(en_sw), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_conflict", 64'(conflict), 64'(0));
    chk("rst_cnt", 64'(conflict_cnt), 64'(0));
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    prst_n = 1'b1;
    tick();
    chk("idle_hold_busy", 64'(busy), 64'(0));

    // Single pair (0,1)
    drive(8'h03, 28'h1);
    exp_q.push_back({8'h03, 28'h1});
    window(60, mk, bz, zr, cf, bk);
    chk("idle_latency", 64'(mk), 64'(SC + 4));
    chk("idle_busy_cycles", 64'(bz), 64'(SC + 2));
    chk("idle_zero_cycles", 64'(zr), 64'(SC + 3));
    chk("idle_break_cycles", 64'(bk), 64'(1));
    chk("idle_conflicts", 64'(cf), 64'(0));
    check_applied("idle_drive");

    // Three switches over poles 0,1,2: only (0,1) wins
    drive(8'h07, 28'h7);
    exp_q.push_back({8'h07, 28'h1});
    window(60, mk, bz, zr, cf, bk);
    chk("conf_latency", 64'(mk), 64'(SC + 4));
    chk("conf_pulses", 64'(cf), 64'(1));
    chk("conf_zero_cycles", 64'(zr), 64'(SC + 2));
    chk("conf_cnt", 64'(conflict_cnt), 64'(CC_ONE));
    check_applied("conf_drive");

    // Orphan switch (6,7) with no poles
    drive(8'h00, 28'h1 << sw_idx(6, 7));
    exp_q.push_back({8'h00, 28'h0});
    window(60, mk, bz, zr, cf, bk);
    chk("orph_latency", 64'(mk), 64'(SC + 4));
    chk("orph_pulses", 64'(cf), 64'(0));
    chk("orph_cnt", 64'(conflict_cnt), 64'(CC_ONE));
    check_applied("orph_drive");

    // Break-before-make: (0,1) then (2,3)
    drive(8'h03, 28'h1);
    exp_q.push_back({8'h03, 28'h1});
    window(60, mk, bz, zr, cf, bk);
    check_applied("bbm_setup_drive");
    drive(8'h0C, 28'h1 << sw_idx(2, 3));
    exp_q.push_back({8'h0C, 28'h20});
    window(60, mk, bz, zr, cf, bk);
    chk("bbm_latency", 64'(mk), 64'(SC + 4));
    chk("bbm_zero_cycles", 64'(zr), 64'(SC + 2));
    check_applied("bbm_drive");

    // Retrigger at cnt=20
    drive(8'h30, 28'h1 << sw_idx(4, 5));
    wait_state(ST_SETTLE, 10, "retrig_reach_settle");
    repeat (20) tick();
    drive(8'h70, 28'h1 << sw_idx(4, 5));
    exp_q.push_back({8'h70, 28'h4000});
    window(60, mk, bz, zr, cf, bk);
    chk("retrig_latency", 64'(mk), 64'(SC + 4));
    chk("retrig_break_cycles", 64'(bk), 64'(1));
    chk("retrig_busy_cycles", 64'(bz), 64'(SC + 3));
    check_applied("retrig_drive");

    // Reset in the middle of SETTLE
    drive(8'h81, 28'h1 << sw_idx(0, 7));
    wait_state(ST_SETTLE, 10, "rstm_reach_settle");
    repeat (10) tick();
    prst_n = 1'b0;
    tick();
    chk("rstm_en_pole", 64'(en_pole), 64'(0));
    chk("rstm_en_sw", 64'(en_sw), 64'(0));
    chk("rstm_busy", 64'(busy), 64'(0));
    chk("rstm_cnt", 64'(conflict_cnt), 64'(0));
    chk("rstm_state", 64'(dbg_state), 64'(ST_IDLE));
    repeat (2) tick();
    prst_n = 1'b1;
    exp_q.push_back({8'h81, 28'h200000});
    window(60, mk, bz, zr, cf, bk);
    chk("rstm_latency", 64'(mk), 64'(SC + 4));
    chk("rstm_zero_cycles", 64'(zr), 64'(SC + 3));
    check_applied("rstm_drive");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/interlock_matrix_ctrl.md
INTERLOCK_MATRIX_CTRL -- requirements
Module: interlock_matrix_ctrl

Interface
REQ-001 SHALL have parameter N_CH, default 8: number of poles.
REQ-002 SHALL have parameter SETTLE_CYC, default 500000: break-to-make dwell in clock cycles. Legal range: at least N_SW+2.
REQ-003 SHALL have localparam N_SW = N_CH*(N_CH-1)/2: number of pole-pair switches.
REQ-004 pclk_50M  input  1  system clock. One clock; reset is synchronous and active-low.
REQ-005 prst_n  input  1  synchronous active-low reset.
REQ-006 req_pole  input  N_CH  requested pole enables, asynchronous to the block.
REQ-007 req_sw  input  N_SW  requested pair switches. Pair (i,j), 0-based with i<j, maps to index j*(j-1)/2+i.
REQ-008 en_pole  output  N_CH  registered pole drive.
REQ-009 en_sw  output  N_SW  registered switch drive.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 conflict  output  1  one-cycle pulse in MAKE when any requested switch was refused.
REQ-012 conflict_cnt  output  16  saturating refusal-event count; see Configuration.

Function
REQ-013 Inputs SHALL pass through a two-stage register: req_q, then req_qq. stable = (req_q == req_qq).
REQ-014 FSM states SHALL be IDLE, BREAK, SETTLE, MAKE.
REQ-015 IDLE -> BREAK when req_q differs from the applied request snapshot; otherwise remain in IDLE.
REQ-016 BREAK lasts 1 cycle.
- en_pole cleared to 0.
- en_sw cleared to 0.
- cnt set to 0.
- Arbiter start pulse issued.
REQ-017 SETTLE increments cnt each cycle.
- If !stable: go to BREAK, restarting dwell and arbitration.
- At cnt == SETTLE_CYC-1: go to MAKE.
REQ-018 Arbiter SHALL scan switches k = 0..N_SW-1, one per cycle, during SETTLE.
- Grant k if req_sw[k] is set, both endpoint poles are requested, and neither endpoint already holds a grant.
- Lowest index wins.
- Result: at most one switch per pole.
REQ-019 A requested switch that is refused SHALL set a per-scan refused flag.
REQ-020 MAKE lasts 1 cycle, then goes to IDLE.
- en_pole <= req_qq.
- en_sw <= grant vector.
- Snapshot <= req_qq.
- conflict <= refused flag.
REQ-021 Latency SHALL be SETTLE_CYC+4 cycles from a stable input change to updated outputs: 2 sync + BREAK + SETTLE_CYC + MAKE.
REQ-022 A switch whose endpoints are unrequested SHALL never be driven, and SHALL NOT count as a conflict.
REQ-023 A request change arriving in MAKE SHALL be applied next, via IDLE -> BREAK.
REQ-024 Outputs SHALL be glitch-free registers. No path from req_* to en_* shall bypass BREAK.

Reset
REQ-025 While prst_n is low at the clock edge, the following SHALL clear:
- en_pole, en_sw, busy, conflict, conflict_cnt = 0.
- State = IDLE.
- cnt, snapshot, sync registers, arbiter = 0.
REQ-026 Reset asserted mid-SETTLE SHALL abort the dwell with no MAKE. After release, a nonzero request SHALL restart from BREAK.

Configuration
REQ-027 Macro IMC_CONFLICT_LOG_EN SHALL control conflict logging.
- Defined: conflict_cnt increments on each MAKE with conflict=1 and saturates at 16'hFFFF.
- Undefined: the counter logic is absent and conflict_cnt is tied to 0. The conflict pulse is unaffected.

Structure
REQ-028 Package imc_pkg SHALL hold:
- State enum imc_state_e.
- Function sw_idx(i,j).
- Functions sw_lo(k) and sw_hi(k).
- Constant CONFLICT_CNT_W = 16.
REQ-029 Sub-module imc_pair_arbiter SHALL hold the serial scan.
- Inputs: start, pole vector, switch vector.
- Outputs: grant vector, refused, done.
- done SHALL assert within N_SW+1 cycles of start.

Verification (N_CH=8, SETTLE_CYC=40)
REQ-030 Idle check: reset, then req_pole=0x03, req_sw bit0 -> outputs stay 0 for 43 cycles, then en_pole=0x03 and en_sw=bit0. busy is high for exactly 42 cycles.
REQ-031 Conflict check: req_pole=0x07 with sw bits 0 (1-2), 1 (1-3) and 2 (2-3) set -> en_sw = bit0 only, conflict pulses once, and conflict_cnt=1 when the macro is defined.
REQ-032 Retrigger check: changing req_pole at cnt=20 in SETTLE -> BREAK re-entered, cnt restarts, and MAKE occurs 40+ cycles after the last change.
REQ-033 Break-before-make check: with a path active, change the request to a different pair -> en_sw and en_pole go to 0 for at least SETTLE_CYC cycles before the new pair drives.
REQ-034 Reset check: assert prst_n low during SETTLE -> all outputs 0 next cycle, and no MAKE occurs.
REQ-035 Orphan check: req_sw bit27 (pair 7-8) set with req_pole=0 -> en_sw stays 0 and there is no conflict pulse.
